// File: rtl/tank_level_emulator_if.sv
// Command/sensor bundle between the irrigation controller (master) and the
// tank emulator (slave).
interface tank_level_emulator_if #(
    parameter int VOL_W = 8
);
    logic             valvulaEntrada;
    logic             gotejamento;
    logic             aspersao;
    logic [1:0]       faultSelect;
    logic             highLevel;
    logic             mediumLevel;
    logic             lowLevel;
    logic [VOL_W-1:0] volume;
    logic             overflow;
    logic             dryRun;

    modport master (
        output valvulaEntrada, gotejamento, aspersao, faultSelect,
        input  highLevel, mediumLevel, lowLevel, volume, overflow, dryRun
    );

    modport slave (
        input  valvulaEntrada, gotejamento, aspersao, faultSelect,
        output highLevel, mediumLevel, lowLevel, volume, overflow, dryRun
    );
endinterface

// File: rtl/tank_level_emulator.sv
// Tank emulator: integrates actuator commands into a clamped volume on each
// prescaler tick and drives registered level sensors with fault injection.
module tank_level_emulator #(
    parameter int VOL_W      = 8,
    parameter int CAPACITY   = 255,
    parameter int INIT_LEVEL = 0,
    parameter int TICK_DIV   = 4,
    parameter int FILL_RATE  = 8,
    parameter int DRIP_RATE  = 2,
    parameter int SPRAY_RATE = 6,
    parameter int LOW_TH     = 32,
    parameter int MED_TH     = 128,
    parameter int HIGH_TH    = 224
) (
    input  logic                  clock,
    input  logic                  reset,
    tank_level_emulator_if.slave  tank
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW    = VOL_W + 2;

    typedef logic signed [SW-1:0] svol_t;

    localparam svol_t FILL_S  = svol_t'(FILL_RATE);
    localparam svol_t DRIP_S  = svol_t'(DRIP_RATE);
    localparam svol_t SPRAY_S = svol_t'(SPRAY_RATE);
    localparam svol_t CAP_S   = svol_t'(CAPACITY);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic             ovf_q, ovf_d;
    logic             dry_q, dry_d;
    logic             high_q, high_d;
    logic             med_q, med_d;
    logic             low_q, low_d;
    logic             tick;
    svol_t            next_vol;

    always_comb begin
        tick  = (pre_q == PRE_W'(TICK_DIV - 1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    // Two extra bits keep the signed sum free of wrap in both directions.
    always_comb begin
        next_vol = $signed({2'b00, vol_q})
                 + (tank.valvulaEntrada ? FILL_S  : '0)
                 - (tank.gotejamento    ? DRIP_S  : '0)
                 - (tank.aspersao       ? SPRAY_S : '0);
        vol_d = vol_q;
        ovf_d = ovf_q;
        dry_d = dry_q;
        if (tick) begin
            if (next_vol > CAP_S) begin
                vol_d = VOL_W'(CAPACITY);
                ovf_d = 1'b1;
            end else if (next_vol[SW-1]) begin
                vol_d = '0;
                dry_d = 1'b1;
            end else begin
                vol_d = next_vol[VOL_W-1:0];
            end
        end
    end

    always_comb begin
        high_d = (vol_q >= VOL_W'(HIGH_TH));
        med_d  = (vol_q >= VOL_W'(MED_TH));
        low_d  = (vol_q >= VOL_W'(LOW_TH));
        case (tank.faultSelect)
            2'b01:   med_d = 1'b0;
            2'b10:   low_d = 1'b0;
            2'b11: begin
                high_d = high_q;
                med_d  = med_q;
                low_d  = low_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q  <= '0;
            vol_q  <= VOL_W'(INIT_LEVEL);
            ovf_q  <= 1'b0;
            dry_q  <= 1'b0;
            high_q <= 1'b0;
            med_q  <= 1'b0;
            low_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            vol_q  <= vol_d;
            ovf_q  <= ovf_d;
            dry_q  <= dry_d;
            high_q <= high_d;
            med_q  <= med_d;
            low_q  <= low_d;
        end
    end

    assign tank.volume      = vol_q;
    assign tank.overflow    = ovf_q;
    assign tank.dryRun      = dry_q;
    assign tank.highLevel   = high_q;
    assign tank.mediumLevel = med_q;
    assign tank.lowLevel    = low_q;
endmodule

// File: tb/tb_tank_level_emulator.sv
// Directed bench for tank_level_emulator with default parameters; expected
// values are hand-computed from the fill/drain rates and tick timing.
module tb_tank_level_emulator;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    tank_level_emulator_if #(.VOL_W(8)) tank_if ();

    tank_level_emulator dut (
        .clock (clock),
        .reset (reset),
        .tank  (tank_if.slave)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        cyc(4 * n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_sens(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {tank_if.highLevel, tank_if.mediumLevel, tank_if.lowLevel};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed HML=%b expected HML=%b", tag, obs, exp);
    endtask

    task automatic cmd(input logic v, input logic g, input logic a);
        tank_if.valvulaEntrada = v;
        tank_if.gotejamento    = g;
        tank_if.aspersao       = a;
    endtask

    initial begin
        cmd(1'b0, 1'b0, 1'b0);
        tank_if.faultSelect = 2'b00;

        // reset state
        cyc(2);
        chk("rst_volume", tank_if.volume, 0);
        chk("rst_overflow", tank_if.overflow, 0);
        chk("rst_dryrun", tank_if.dryRun, 0);
        chk_sens("rst_sensors", 3'b000);

        // fill from empty: first tick on the 4th edge after release
        reset = 1'b0;
        cmd(1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("fill_pre_tick", tank_if.volume, 0);
        cyc(1);
        chk("fill_t1", tank_if.volume, 8);
        ticks(1);
        chk("fill_t2", tank_if.volume, 16);
        ticks(1);
        chk("fill_t3", tank_if.volume, 24);
        ticks(1);
        chk("fill_t4", tank_if.volume, 32);
        chk_sens("low_lag", 3'b000);
        cyc(1);
        chk_sens("low_set", 3'b001);
        cyc(3);
        chk("fill_t5", tank_if.volume, 40);

        // reach 240, medium stuck-at-0 fault
        ticks(25);
        chk("fill_240", tank_if.volume, 240);
        tank_if.faultSelect = 2'b01;
        cyc(1);
        chk_sens("fault01", 3'b101);
        cyc(3);
        chk("fill_248", tank_if.volume, 248);
        chk("ovf_before", tank_if.overflow, 0);
        ticks(1);
        chk("clamp_255", tank_if.volume, 255);
        chk("ovf_set", tank_if.overflow, 1);

        // freeze sensors while draining below HIGH_TH
        tank_if.faultSelect = 2'b11;
        cmd(1'b0, 1'b1, 1'b1);
        ticks(1);
        chk("drain_247", tank_if.volume, 247);
        chk("ovf_sticky", tank_if.overflow, 1);
        ticks(3);
        chk("drain_223", tank_if.volume, 223);
        chk_sens("frozen", 3'b101);
        tank_if.faultSelect = 2'b00;
        cyc(1);
        chk_sens("unfrozen", 3'b011);
        cyc(3);
        chk("drain_215", tank_if.volume, 215);

        // drain to empty, clamp at 0
        ticks(26);
        chk("drain_7", tank_if.volume, 7);
        chk("dry_before", tank_if.dryRun, 0);
        ticks(1);
        chk("clamp_0", tank_if.volume, 0);
        chk("dry_set", tank_if.dryRun, 1);
        cmd(1'b0, 1'b0, 1'b1);
        ticks(3);
        chk("spray_empty", tank_if.volume, 0);
        chk("dry_sticky", tank_if.dryRun, 1);
        chk_sens("empty_sensors", 3'b000);

        // climb to 100, then net-zero combination
        cmd(1'b1, 1'b0, 1'b0);
        ticks(11);
        chk("fill_88", tank_if.volume, 88);
        cmd(1'b1, 1'b1, 1'b0);
        ticks(2);
        chk("fill_drip_100", tank_if.volume, 100);
        cmd(1'b1, 1'b1, 1'b1);
        ticks(2);
        chk("net_zero", tank_if.volume, 100);
        cmd(1'b1, 1'b0, 1'b1);
        ticks(1);
        chk("net_102", tank_if.volume, 102);
        ticks(1);
        chk("net_104", tank_if.volume, 104);

        // low stuck-at-0 fault
        cmd(1'b0, 1'b0, 1'b0);
        tank_if.faultSelect = 2'b10;
        cyc(1);
        chk_sens("fault10", 3'b000);
        tank_if.faultSelect = 2'b00;
        cyc(1);
        chk_sens("fault10_clear", 3'b001);
        cyc(2);

        // a valve pulse between ticks is ignored
        cmd(1'b1, 1'b0, 1'b0);
        cyc(1);
        cmd(1'b0, 1'b0, 1'b0);
        cyc(3);
        chk("pulse_ignored", tank_if.volume, 104);

        // reach 150 with overflow still set, then reset mid-run
        cmd(1'b1, 1'b0, 1'b0);
        ticks(5);
        chk("fill_144", tank_if.volume, 144);
        cmd(1'b1, 1'b1, 1'b0);
        ticks(1);
        chk("fill_150", tank_if.volume, 150);
        chk("ovf_at_150", tank_if.overflow, 1);
        chk_sens("sens_150", 3'b011);
        cmd(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_volume", tank_if.volume, 0);
        chk("mid_rst_ovf", tank_if.overflow, 0);
        chk("mid_rst_dry", tank_if.dryRun, 0);
        chk_sens("mid_rst_sensors", 3'b000);
        reset = 1'b0;
        cyc(3);
        chk("post_rst_pre_tick", tank_if.volume, 0);
        chk_sens("post_rst_sensors", 3'b000);
        cyc(1);
        chk("post_rst_t1", tank_if.volume, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tank_level_emulator.md
Name: tank_level_emulator

Overview:
- Closed-loop emulator of the irrigation water tank. It is the sensor end of the tank interface that the irrigation controller reads.
- It consumes the controller's actuator commands (valvulaEntrada, gotejamento, aspersao) and integrates a tank volume over time.
- It drives the three level sensors (highLevel, mediumLevel, lowLevel) back to the controller.
- It includes sensor fault injection so the controller's erro/alarme paths can be exercised on the FPGA without a physical tank.

Parameters:
- VOL_W, 8, volume register width (bits).
- CAPACITY, 255, maximum volume; must be ≤ 2^VOL_W−1.
- INIT_LEVEL, 0, volume loaded on reset.
- TICK_DIV, 4, clock cycles per integration tick (≥1).
- FILL_RATE, 8, volume added per tick while valvulaEntrada=1.
- DRIP_RATE, 2, volume removed per tick while gotejamento=1.
- SPRAY_RATE, 6, volume removed per tick while aspersao=1.
- LOW_TH, 32, lowLevel threshold (volume ≥ LOW_TH → 1).
- MED_TH, 128, mediumLevel threshold.
- HIGH_TH, 224, highLevel threshold; require LOW_TH < MED_TH < HIGH_TH ≤ CAPACITY.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- valvulaEntrada  in  1  inlet valve open (fills tank).
- gotejamento  in  1  drip irrigation active (drains DRIP_RATE).
- aspersao  in  1  sprinkler active (drains SPRAY_RATE).
- faultSelect  in  2  00 normal; 01 mediumLevel stuck 0; 10 lowLevel stuck 0; 11 sensors frozen.
- highLevel  out  1  registered high sensor.
- mediumLevel  out  1  registered medium sensor.
- lowLevel  out  1  registered low sensor.
- volume  out  VOL_W  current tank volume.
- overflow  out  1  sticky: fill was clamped at CAPACITY.
- dryRun  out  1  sticky: drain was clamped at 0.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it has priority over every other operation in the same cycle.
- Reset values:
  - prescaler = 0
  - volume = INIT_LEVEL
  - highLevel, mediumLevel, lowLevel = 0
  - overflow = 0, dryRun = 0
- Prescaler:
  - Counts 0..TICK_DIV−1 and wraps to 0.
  - tick = (prescaler == TICK_DIV−1). With TICK_DIV=1, tick is asserted every cycle.
  - First tick falls on the TICK_DIV-th cycle after reset deasserts.
- Integration, on tick only:
  - delta = (valvulaEntrada ? FILL_RATE : 0) − (gotejamento ? DRIP_RATE : 0) − (aspersao ? SPRAY_RATE : 0).
  - Compute next = volume + delta in a signed width of VOL_W+2 bits, so there is no wrap.
  - next > CAPACITY → volume = CAPACITY, overflow ← 1.
  - next < 0 → volume = 0, dryRun ← 1.
  - Otherwise volume = next.
  - Simultaneous commands combine additively within the same tick. There is no priority between actuators.
  - Commands are sampled only in the tick cycle; pulses between ticks are ignored.
- volume is held between ticks. overflow and dryRun clear only on reset.
- Sensors, registered every cycle:
  - Raw values: rawH = volume ≥ HIGH_TH, rawM = volume ≥ MED_TH, rawL = volume ≥ LOW_TH.
  - Latency: sensors reflect a volume change 1 clock after the volume register updates (tick edge +1).
- faultSelect effect on the sensor registers:
  - 00: sensor regs ← raw values.
  - 01: mediumLevel ← 0; others raw. Produces H·M' or M·L'-type inconsistency when volume ≥ HIGH_TH.
  - 10: lowLevel ← 0; others raw.
  - 11: all three sensor regs hold their current value. Volume integration continues.
- faultSelect changes take effect on the next clock edge. Leaving 11 resumes tracking on the next edge.
- Reset mid-operation: volume returns to INIT_LEVEL and the prescaler restarts at 0. Sensors read 0 for the reset cycle, then reflect INIT_LEVEL 1 cycle after reset deasserts.

Test Plan:
- Reset, valvulaEntrada=1 only, defaults → volume 8,16,24,32 at cycles 4,8,12,16; lowLevel=1 at cycle 17; mediumLevel=0.
- Hold fill from 248 → next tick volume=255 (not 256/0), overflow=1 and remains 1 after valve closes.
- volume=0, aspersao=1 for 3 ticks → volume stays 0, dryRun=1, all sensors 0.
- volume=100, valvulaEntrada=1 + aspersao=1 + gotejamento=1 → net 0 per tick, volume stays 100; drop gotejamento → 102, 104 on successive ticks.
- volume=240, faultSelect=01 → next cycle highLevel=1, mediumLevel=0, lowLevel=1; faultSelect=11 while draining past 224 → sensors unchanged until faultSelect=00.
- Assert reset for 1 cycle at volume=150 with overflow=1 → volume=0, overflow=0, sensors 0; first tick 4 cycles after release.
